// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals for mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory (environment side).
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_we;
  logic [2:0]  d_func3;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_data;
  logic        d_rsp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;

  modport slave (
    input  if_req_valid, if_addr,
    input  d_req_valid, d_we, d_func3, d_addr, d_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output if_req_valid, if_addr,
    output d_req_valid, d_we, d_func3, d_addr, d_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto a single 64-bit memory port, one transaction in flight.
// Optional MISALIGN_CHECK_EN: reject misaligned data accesses with an error response.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_IF = 2'd1;
  localparam logic [1:0] WAIT_D  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] starve_cnt;
  logic          if_hi_q;
  logic          d_we_q;
  logic [2:0]    d_off_q;
  logic [2:0]    d_f3_q;

  logic idle, sel_if, sel_d, d_bad, d_mem, hs_if, hs_d, acc_bad;

  assign idle   = (state == IDLE) && !rst;
  assign sel_if = idle && bus.if_req_valid && (!bus.d_req_valid || starve_cnt == LIMIT);
  assign sel_d  = idle && bus.d_req_valid && !sel_if;

`ifdef MISALIGN_CHECK_EN
  logic mis;
  always_comb begin
    case (bus.d_func3[1:0])
      2'b01:   mis = bus.d_addr[0];
      2'b10:   mis = |bus.d_addr[1:0];
      2'b11:   mis = |bus.d_addr[2:0];
      default: mis = 1'b0;
    endcase
  end
  assign d_bad = mis || (bus.d_we && bus.d_func3[2]);
`else
  assign d_bad = 1'b0;
`endif

  assign d_mem   = sel_d && !d_bad;
  assign hs_if   = sel_if && bus.mem_req_ready;
  assign hs_d    = d_mem && bus.mem_req_ready;
  assign acc_bad = sel_d && d_bad;

  assign bus.mem_req_valid = sel_if || d_mem;
  assign bus.if_req_ready  = hs_if;
  assign bus.d_req_ready   = hs_d || acc_bad;

  // Store lane placement; bytes shifted past bit 63 are dropped, never wrapped.
  logic [7:0] strb_base;
  always_comb begin
    case (bus.d_func3[1:0])
      2'b00:   strb_base = 8'h01;
      2'b01:   strb_base = 8'h03;
      2'b10:   strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  assign bus.mem_we    = d_mem && bus.d_we;
  assign bus.mem_addr  = sel_if ? {bus.if_addr[63:3], 3'b000} :
                         d_mem  ? {bus.d_addr[63:3], 3'b000}  : 64'd0;
  assign bus.mem_wstrb = (d_mem && bus.d_we) ? (strb_base << bus.d_addr[2:0]) : 8'd0;
  assign bus.mem_wdata = (d_mem && bus.d_we) ? (bus.d_wdata << {bus.d_addr[2:0], 3'b000}) : 64'd0;

  // Load extraction uses the offset/width captured at the handshake.
  logic [63:0] ld_sh, ld_val;
  assign ld_sh = bus.mem_rsp_data >> {d_off_q, 3'b000};
  always_comb begin
    case (d_f3_q)
      3'b000:  ld_val = {{56{ld_sh[7]}},  ld_sh[7:0]};
      3'b001:  ld_val = {{48{ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_val = {{32{ld_sh[31]}}, ld_sh[31:0]};
      3'b100:  ld_val = {56'd0, ld_sh[7:0]};
      3'b101:  ld_val = {48'd0, ld_sh[15:0]};
      3'b110:  ld_val = {32'd0, ld_sh[31:0]};
      default: ld_val = ld_sh;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  logic err_q;
  assign bus.d_rsp_err = err_q;
`else
  assign bus.d_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      if_hi_q          <= 1'b0;
      d_we_q           <= 1'b0;
      d_off_q          <= 3'd0;
      d_f3_q           <= 3'd0;
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_data  <= 32'd0;
      bus.d_rsp_valid  <= 1'b0;
      bus.d_rsp_data   <= 64'd0;
`ifdef MISALIGN_CHECK_EN
      err_q            <= 1'b0;
`endif
    end else begin
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_data  <= 32'd0;
      bus.d_rsp_valid  <= 1'b0;
      bus.d_rsp_data   <= 64'd0;
`ifdef MISALIGN_CHECK_EN
      err_q            <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (hs_if) begin
            state   <= WAIT_IF;
            if_hi_q <= bus.if_addr[2];
          end else if (hs_d) begin
            state   <= WAIT_D;
            d_we_q  <= bus.d_we;
            d_off_q <= bus.d_addr[2:0];
            d_f3_q  <= bus.d_func3;
          end else if (acc_bad) begin
            bus.d_rsp_valid <= 1'b1;
`ifdef MISALIGN_CHECK_EN
            err_q           <= 1'b1;
`endif
          end
        end
        WAIT_IF: if (bus.mem_rsp_valid) begin
          state            <= IDLE;
          bus.if_rsp_valid <= 1'b1;
          bus.if_rsp_data  <= if_hi_q ? bus.mem_rsp_data[63:32] : bus.mem_rsp_data[31:0];
        end
        WAIT_D: if (bus.mem_rsp_valid) begin
          state           <= IDLE;
          bus.d_rsp_valid <= 1'b1;
          bus.d_rsp_data  <= d_we_q ? 64'd0 : ld_val;
        end
        default: state <= IDLE;
      endcase

      // Data may win ties up to STARVE_LIMIT times in a row while fetch waits.
      if (hs_if)
        starve_cnt <= '0;
      else if (bus.d_req_ready)
        starve_cnt <= !bus.if_req_valid ? '0 :
                      (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + CW'(1);
    end
  end
endmodule
